uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one byte-wide UART transmitter between N_REQ frame sources. Each source presents a fixed-length wide frame.
- A round-robin arbiter grants one source at a time, latches that source's frame, and serializes it byte by byte over the UART's send/busy handshake.
- Sits between the DMA/SPI capture blocks and the single UART TX, both in the debug bench and on-chip.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FRAME_BYTES, 51, bytes per frame (1..255).
- DATA_W, FRAME_BYTES*8, frame width in bits (derived; not overridable).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  N_REQ  per-source frame request; a source holds its bit high with data stable until it sees its ack bit.
- data_in  in  N_REQ*DATA_W  source i frame occupies bits [i*DATA_W +: DATA_W].
- ack  out  N_REQ  one-cycle pulse; frame of that source latched.
- uart_busy  in  1  UART transmitter busy.
- uart_data  out  8  byte to transmit; valid while uart_send is high.
- uart_send  out  1  one-cycle transmit strobe.
- active_id  out  $clog2(N_REQ)  index of the source being serialized.
- frame_done  out  1  one-cycle pulse after the last byte is accepted and uart_busy has fallen.

Behaviour:
- Reset values: ack=0, uart_data=0, uart_send=0, active_id=0, frame_done=0, rr_ptr=N_REQ-1, state=IDLE, byte counter=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately. No further strobes are issued; the partial frame is lost and no ack is re-issued.
- States: IDLE, GRANT, LOAD, STROBE, GAP, WAIT_TX, DONE.
- IDLE:
  - If any req bit is set, select the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - Register the winner into active_id and go to GRANT.
  - Selection is combinational on req in IDLE only. req changes while not in IDLE are ignored.
- GRANT (1 cycle):
  - Latch data_in slice of active_id into the DATA_W shift register.
  - Pulse ack[active_id].
  - Set rr_ptr=active_id and byte counter=FRAME_BYTES. Go to LOAD.
- LOAD:
  - If uart_busy=0, go to STROBE. Otherwise wait in LOAD.
- STROBE (1 cycle):
  - uart_send=1 and uart_data=shift[DATA_W-1 -: 8]. Bytes go out MSB first.
  - Shift register <<= 8 with zero fill. Counter -=1. Go to GAP.
- GAP (1 cycle):
  - uart_busy is ignored here, because the UART raises busy the cycle after the strobe. Go to WAIT_TX.
- WAIT_TX:
  - Stay while uart_busy=1.
  - On uart_busy=0: if counter>0, go to STROBE; if counter=0, go to DONE.
- DONE (1 cycle):
  - frame_done=1. Go to IDLE.
  - The next grant can occur no earlier than 2 cycles after frame_done.
- Strobe timing:
  - Minimum spacing between strobes is 3 cycles (STROBE, GAP, WAIT_TX with busy already low).
  - uart_send is never high on two consecutive cycles.
  - uart_data holds its value until the next strobe.
- Fairness:
  - A source that has just been served has the lowest priority on the next arbitration.
  - With all req bits held high, grants rotate 0,1,2,...,N_REQ-1,0,...
- Simultaneous events:
  - req deasserting in GRANT does not cancel the frame; the frame is latched regardless.
  - A req bit still high after its ack is treated as a new request at the next IDLE.

Optional Feature:
- Macro: UART_ARB_FRAMING_EN.
- Defined:
  - Each frame is wrapped with a header byte 0xA0|active_id, sent before the payload.
  - After the payload, a checksum byte is sent: XOR of all FRAME_BYTES payload bytes (header excluded).
  - Both use the same STROBE/GAP/WAIT_TX handshake. Total bytes per frame = FRAME_BYTES+2.
  - frame_done fires after the checksum byte completes.
- Undefined:
  - Payload only; no extra logic or state.

Test Plan:
- Single request: req=4'b0001, frame bytes 0x01..0x33 → ack[0] pulses once, 51 strobes carrying 0x01..0x33 in order, then frame_done. UART model holds busy 10 cycles per byte.
- Round-robin: req=4'b1111 held for 5 frames → active_id sequence 0,1,2,3,0, each ack pulsed exactly once per frame.
- Priority after service: after serving source 2, assert req=4'b0101 → source 0 granted next, not source 2.
- Busy at grant: uart_busy held high 20 cycles during LOAD → no strobe until 1 cycle after busy falls; first byte still correct.
- Reset mid-frame: rst_n low after byte 10 of a frame → all outputs return to reset values next cycle. With req=4'b0010, the next grant goes to source 1 (rr_ptr=3 after reset).
- UART_ARB_FRAMING_EN defined, source 3, payload all 0x5A → first byte 0xA3, 51 bytes of 0x5A, checksum 0x5A, then frame_done.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that grants one of N_REQ frame sources and serializes its frame MSB-first
// over a byte UART send/busy handshake. Define UART_ARB_FRAMING_EN to add a header and checksum byte.
module uart_tx_arbiter #(
   parameter int N_REQ       = 4,
   parameter int FRAME_BYTES = 51
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N_REQ-1:0]               req,
   input  logic [N_REQ*FRAME_BYTES*8-1:0] data_in,
   output logic [N_REQ-1:0]               ack,
   input  logic                           uart_busy,
   output logic [7:0]                     uart_data,
   output logic                           uart_send,
   output logic [$clog2(N_REQ)-1:0]       active_id,
   output logic                           frame_done,
   output logic [2:0]                     fsm_state
);

   // Source handshake: req[i] stays high with its data_in slice stable until ack[i] pulses;
   // the frame is captured in that same cycle. UART handshake: uart_send strobes one byte,
   // the UART raises uart_busy the following cycle and drops it when ready for more.
   localparam int DATA_W = FRAME_BYTES * 8;
   localparam int ID_W   = $clog2(N_REQ);
`ifdef UART_ARB_FRAMING_EN
   localparam int TOTAL  = FRAME_BYTES + 2;
`else
   localparam int TOTAL  = FRAME_BYTES;
`endif
   localparam int CNT_W  = $clog2(TOTAL + 1);
   localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);

   typedef enum logic [2:0] {IDLE, GRANT, LOAD, STROBE, GAP, WAIT_TX, DONE} state_t;

   state_t            state, state_nx;
   logic [ID_W-1:0]   rr_ptr, winner, idx;
   logic              found;
   logic [DATA_W-1:0] shift;
   logic [CNT_W-1:0]  cnt;
   logic [7:0]        data_q, tx_byte;
   logic [DATA_W-1:0] frames [N_REQ];
`ifdef UART_ARB_FRAMING_EN
   logic [7:0]        csum;
   logic              payload;
`endif

   for (genvar i = 0; i < N_REQ; i++) begin : g_slice
      assign frames[i] = data_in[i*DATA_W +: DATA_W];
   end

   // First set req bit after rr_ptr, wrapping, so the last-served source ranks lowest.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

`ifdef UART_ARB_FRAMING_EN
   always_comb begin
      payload = 1'b0;
      tx_byte = shift[DATA_W-1 -: 8];
      if (cnt == TOTAL_C) begin
         tx_byte = 8'hA0 | 8'(active_id);
      end else if (cnt == CNT_W'(1)) begin
         tx_byte = csum;
      end else begin
         payload = 1'b1;
      end
   end
`else
   assign tx_byte = shift[DATA_W-1 -: 8];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      ack        = '0;
      uart_send  = 1'b0;
      uart_data  = data_q;
      frame_done = 1'b0;
      case (state)
         IDLE:    if (found) state_nx = GRANT;
         GRANT: begin
            ack[active_id] = 1'b1;
            state_nx       = LOAD;
         end
         LOAD:    if (!uart_busy) state_nx = STROBE;
         STROBE: begin
            uart_send = 1'b1;
            uart_data = tx_byte;
            state_nx  = GAP;
         end
         GAP:     state_nx = WAIT_TX;
         WAIT_TX: if (!uart_busy) state_nx = (cnt != '0) ? STROBE : DONE;
         DONE: begin
            frame_done = 1'b1;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr    <= ID_W'(N_REQ - 1);
         active_id <= '0;
         shift     <= '0;
         cnt       <= '0;
         data_q    <= '0;
`ifdef UART_ARB_FRAMING_EN
         csum      <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (found) active_id <= winner;
            GRANT: begin
               shift  <= frames[active_id];
               cnt    <= TOTAL_C;
               rr_ptr <= active_id;
`ifdef UART_ARB_FRAMING_EN
               csum   <= '0;
`endif
            end
            STROBE: begin
               data_q <= tx_byte;
               cnt    <= cnt - 1'b1;
`ifdef UART_ARB_FRAMING_EN
               if (payload) begin
                  shift <= shift << 8;
                  csum  <= csum ^ tx_byte;
               end
`else
               shift  <= shift << 8;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
